// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
//   BRAM port-A handshake between the multicycle sequencer and the memory.
//
//   instr_in   read data from BRAM port A (memory -> controller)
//   mem_ready  access complete this cycle (memory -> controller)
//   mem_en     access request (controller -> memory)
//   mem_we     write strobe, qualified by mem_en (controller -> memory)
//   addr_sel   0 = address from pc, 1 = from data address register
//
//   modport master : the sequencer side
//   modport slave  : the memory side
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] instr_in;
    logic              mem_ready;
    logic              mem_en;
    logic              mem_we;
    logic              addr_sel;

    modport master (
        input  instr_in,
        input  mem_ready,
        output mem_en,
        output mem_we,
        output addr_sel
    );

    modport slave (
        output instr_in,
        output mem_ready,
        input  mem_en,
        input  mem_we,
        input  addr_sel
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle control sequencer. Owns pc and ir and steps each instruction
//   through FETCH / FETCH_WAIT / DECODE / EXECUTE / MEM / MEM_WAIT /
//   WRITEBACK, with HALT as a terminal state left only through reset.
//   The memory has variable latency and answers with mem_ready.
//
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   run_en       1 = a new fetch may start; 0 = pause before next fetch
//   mem          BRAM handshake (multicycle_ctrl_if.master)
//   is_load, is_store, is_branch, is_jump, is_halt
//                decoder flags for the instruction held in ir
//   br_taken     branch condition result
//   br_disp      signed branch displacement
//   jump_target  absolute jump destination
//   pc, ir       program counter / instruction register
//   reg_we       register-file write enable (one cycle, WRITEBACK)
//   alu_en       ALU/flag update enable (one cycle, EXECUTE)
//   state        current state encoding (debug)
//   halted       high while in HALT
//
//   Every output is a register, so no input reaches an output
//   combinationally.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 16,
    parameter int                 DISP_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_en,
    multicycle_ctrl_if.master   mem,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                is_branch,
    input  logic                br_taken,
    input  logic [DISP_W-1:0]   br_disp,
    input  logic                is_jump,
    input  logic [ADDR_W-1:0]   jump_target,
    input  logic                is_halt,
    output logic [ADDR_W-1:0]   pc,
    output logic [DATA_W-1:0]   ir,
    output logic                reg_we,
    output logic                alu_en,
    output logic [2:0]          state,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_MEM        = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WRITEBACK  = 3'd6,
        S_HALT       = 3'd7
    } state_t;

    state_t st;

    // A size cast of a signed operand sign-extends, which also covers
    // DISP_W == ADDR_W where a zero-width replication would be illegal.
    logic [ADDR_W-1:0] disp_ext;
    assign disp_ext = ADDR_W'($signed(br_disp));

    // An instruction is an ALU op when no other decoder class claims it.
    logic is_alu;
    assign is_alu = !(is_halt || is_jump || is_branch || is_load || is_store);

    assign state = st;

    // NOTE: every register here, including pc and ir, is cleared by the async
    // reset; there is no memory array, so nothing is left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= S_FETCH;
            pc           <= RESET_PC;
            ir           <= '0;
            mem.mem_en   <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.addr_sel <= 1'b0;
            reg_we       <= 1'b0;
            alu_en       <= 1'b0;
            halted       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every register sees the
            // pre-edge values of the others regardless of statement order.
            case (st)
                S_FETCH: begin
                    reg_we <= 1'b0;
                    if (run_en) begin
                        st           <= S_FETCH_WAIT;
                        mem.mem_en   <= 1'b1;
                        mem.addr_sel <= 1'b0;
                        mem.mem_we   <= 1'b0;
                    end
                end

                S_FETCH_WAIT: begin
                    if (mem.mem_ready) begin
                        ir         <= mem.instr_in;
                        pc         <= pc + 1'b1;
                        mem.mem_en <= 1'b0;
                        st         <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    // ir has been stable since the fetch edge, so the decoder
                    // flags already hold their EXECUTE values; registering
                    // alu_en here makes it high exactly during EXECUTE.
                    alu_en <= is_alu;
                    st     <= S_EXECUTE;
                end

                S_EXECUTE: begin
                    alu_en <= 1'b0;
                    if (is_halt) begin
                        halted <= 1'b1;
                        st     <= S_HALT;
                    end else if (is_jump) begin
                        pc <= jump_target;
                        st <= S_FETCH;
                    end else if (is_branch) begin
                        // pc already points past the branch.
                        if (br_taken) pc <= pc + disp_ext;
                        st <= S_FETCH;
                    end else if (is_load || is_store) begin
                        mem.mem_en   <= 1'b1;
                        mem.addr_sel <= 1'b1;
                        mem.mem_we   <= is_store;
                        st           <= S_MEM;
                    end else begin
                        reg_we <= 1'b1;
                        st     <= S_WRITEBACK;
                    end
                end

                S_MEM: begin
                    // A ready seen here belongs to no request yet; ignore it.
                    st <= S_MEM_WAIT;
                end

                S_MEM_WAIT: begin
                    if (mem.mem_ready) begin
                        mem.mem_en   <= 1'b0;
                        mem.addr_sel <= 1'b0;
                        mem.mem_we   <= 1'b0;
                        // mem_we still identifies the access as a store.
                        if (mem.mem_we) begin
                            st <= S_FETCH;
                        end else begin
                            reg_we <= 1'b1;
                            st     <= S_WRITEBACK;
                        end
                    end
                end

                S_WRITEBACK: begin
                    reg_we <= 1'b0;
                    st     <= S_FETCH;
                end

                S_HALT: begin
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Inputs change 1 ns after a rising
//   edge and outputs are sampled there, away from the active edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int DISP_W = 8;

    logic              clk;
    logic              reset;
    logic              run_en;
    logic              is_load, is_store, is_branch, br_taken, is_jump, is_halt;
    logic [DISP_W-1:0] br_disp;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              reg_we, alu_en, halted;
    logic [2:0]        state;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl_if #(.DATA_W(DATA_W)) mem_bus ();

    multicycle_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DISP_W  (DISP_W),
        .RESET_PC(16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_en     (run_en),
        .mem        (mem_bus),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .br_taken   (br_taken),
        .br_disp    (br_disp),
        .is_jump    (is_jump),
        .jump_target(jump_target),
        .is_halt    (is_halt),
        .pc         (pc),
        .ir         (ir),
        .reg_we     (reg_we),
        .alu_en     (alu_en),
        .state      (state),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        is_load = 0; is_store = 0; is_branch = 0; br_taken = 0;
        is_jump = 0; is_halt = 0; br_disp = '0; jump_target = '0;
    endtask

    // Fetch (ready=1) then jump; ends back in FETCH.
    task automatic do_jump(input logic [ADDR_W-1:0] target);
        tick();                       // FETCH_WAIT
        tick();                       // DECODE
        is_jump = 1; jump_target = target;
        tick();                       // EXECUTE
        tick();                       // FETCH
        clear_flags();
    endtask

    // Fetch (ready=1) then branch; ends back in FETCH.
    task automatic do_branch(input logic taken, input logic [DISP_W-1:0] disp);
        tick();
        tick();
        is_branch = 1; br_taken = taken; br_disp = disp;
        tick();
        tick();
        clear_flags();
    endtask

    initial begin
        reset = 0; run_en = 0;
        mem_bus.instr_in = '0; mem_bus.mem_ready = 0;
        clear_flags();

        // ---- reset state ----
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_strobes", {28'd0, mem_bus.mem_en, mem_bus.mem_we, reg_we, alu_en}, 32'd0);
        check("rst_addr_sel", 32'(mem_bus.addr_sel), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // ---- ALU op, ready every cycle: 0,1,2,3,6,0 ----
        reset = 1; run_en = 1; mem_bus.mem_ready = 1; mem_bus.instr_in = 16'h1234;
        check("alu_f_state", 32'(state), 32'd0);
        check("alu_f_mem_en", 32'(mem_bus.mem_en), 32'd0);
        tick();
        check("alu_fw_state", 32'(state), 32'd1);
        check("alu_fw_mem_en", 32'(mem_bus.mem_en), 32'd1);
        check("alu_fw_addr_sel", 32'(mem_bus.addr_sel), 32'd0);
        tick();
        check("alu_d_state", 32'(state), 32'd2);
        check("alu_d_ir", 32'(ir), 32'h1234);
        check("alu_d_pc", 32'(pc), 32'h1);
        check("alu_d_alu_en", 32'(alu_en), 32'd0);
        tick();
        check("alu_e_state", 32'(state), 32'd3);
        check("alu_e_alu_en", 32'(alu_en), 32'd1);
        check("alu_e_reg_we", 32'(reg_we), 32'd0);
        tick();
        check("alu_wb_state", 32'(state), 32'd6);
        check("alu_wb_alu_en", 32'(alu_en), 32'd0);
        check("alu_wb_reg_we", 32'(reg_we), 32'd1);
        tick();
        check("alu_end_state", 32'(state), 32'd0);
        check("alu_end_reg_we", 32'(reg_we), 32'd0);

        // ---- fetch with 3 wait cycles, then a load with 2 wait cycles ----
        mem_bus.instr_in = 16'hABCD;
        tick();                               // FETCH_WAIT
        mem_bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fwait_state", 32'(state), 32'd1);
            check("fwait_mem_en", 32'(mem_bus.mem_en), 32'd1);
            check("fwait_pc", 32'(pc), 32'h1);
            check("fwait_ir", 32'(ir), 32'h1234);
        end
        mem_bus.mem_ready = 1;
        tick();
        check("fwait_done_state", 32'(state), 32'd2);
        check("fwait_done_ir", 32'(ir), 32'hABCD);
        check("fwait_done_pc", 32'(pc), 32'h2);
        is_load = 1;
        tick();
        check("ld_e_state", 32'(state), 32'd3);
        check("ld_e_alu_en", 32'(alu_en), 32'd0);
        tick();                               // MEM; ready=1 here must be ignored
        check("ld_mem_state", 32'(state), 32'd4);
        check("ld_mem_bus", {29'd0, mem_bus.mem_en, mem_bus.addr_sel, mem_bus.mem_we}, 32'b110);
        tick();
        check("ld_mw_state", 32'(state), 32'd5);
        mem_bus.mem_ready = 0;
        tick(); tick();
        check("ld_mw_hold_state", 32'(state), 32'd5);
        check("ld_mw_hold_bus", {29'd0, mem_bus.mem_en, mem_bus.addr_sel, mem_bus.mem_we}, 32'b110);
        mem_bus.mem_ready = 1;
        tick();
        check("ld_wb_state", 32'(state), 32'd6);
        check("ld_wb_reg_we", 32'(reg_we), 32'd1);
        check("ld_wb_bus", {29'd0, mem_bus.mem_en, mem_bus.addr_sel, mem_bus.mem_we}, 32'b000);
        clear_flags();
        tick();
        check("ld_end_state", 32'(state), 32'd0);
        check("ld_end_pc", 32'(pc), 32'h2);

        // ---- store, ready every cycle: 6 cycles, no reg_we ----
        mem_bus.instr_in = 16'h5000;
        tick(); tick();
        is_store = 1;
        tick();                               // EXECUTE
        tick();
        check("st_mem_state", 32'(state), 32'd4);
        check("st_mem_bus", {29'd0, mem_bus.mem_en, mem_bus.addr_sel, mem_bus.mem_we}, 32'b111);
        tick();
        check("st_mw_state", 32'(state), 32'd5);
        check("st_mw_bus", {29'd0, mem_bus.mem_en, mem_bus.addr_sel, mem_bus.mem_we}, 32'b111);
        check("st_mw_reg_we", 32'(reg_we), 32'd0);
        tick();
        check("st_end_state", 32'(state), 32'd0);
        check("st_end_we", {30'd0, mem_bus.mem_we, reg_we}, 32'd0);
        check("st_end_pc", 32'(pc), 32'h3);
        clear_flags();

        // ---- jump and branches ----
        do_jump(16'h0010);
        check("jmp_pc", 32'(pc), 32'h0010);
        check("jmp_state", 32'(state), 32'd0);
        do_branch(1'b1, 8'hFC);
        check("br_taken_pc", 32'(pc), 32'h000D);
        do_jump(16'h0010);
        do_branch(1'b0, 8'hFC);
        check("br_not_taken_pc", 32'(pc), 32'h0011);
        do_jump(16'hFFFF);
        tick(); tick();
        check("wrap_fetch_pc", 32'(pc), 32'h0000);
        is_branch = 1; br_taken = 1; br_disp = 8'h01;
        tick(); tick();
        clear_flags();
        check("br_wrap_pc", 32'(pc), 32'h0001);

        // ---- jump + halt together: halt wins ----
        tick(); tick();                       // pc -> 2
        is_jump = 1; is_halt = 1; jump_target = 16'h1234;
        tick(); tick();
        check("halt_state", 32'(state), 32'd7);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'h0002);
        clear_flags();
        run_en = 0; tick(); run_en = 1; tick(); tick();
        check("halt_hold_state", 32'(state), 32'd7);
        check("halt_hold_mem_en", 32'(mem_bus.mem_en), 32'd0);
        reset = 0; #1;                        // asynchronous, no edge
        check("halt_rst_state", 32'(state), 32'd0);
        check("halt_rst_pc", 32'(pc), 32'h0000);
        check("halt_rst_halted", 32'(halted), 32'd0);
        tick(); reset = 1;

        // ---- reset in the middle of a fetch ----
        mem_bus.instr_in = 16'h7777; mem_bus.mem_ready = 0;
        tick();
        check("mid_fw_mem_en", 32'(mem_bus.mem_en), 32'd1);
        reset = 0; #1;
        check("mid_rst_mem_en", 32'(mem_bus.mem_en), 32'd0);
        check("mid_rst_ir", 32'(ir), 32'h0000);
        check("mid_rst_pc", 32'(pc), 32'h0000);
        tick(); reset = 1; mem_bus.mem_ready = 1;

        // ---- run_en dropped during EXECUTE: finish, then pause ----
        mem_bus.instr_in = 16'h0042;
        tick(); tick(); tick();               // EXECUTE
        check("pause_e_state", 32'(state), 32'd3);
        run_en = 0;
        tick();
        check("pause_wb_state", 32'(state), 32'd6);
        check("pause_wb_reg_we", 32'(reg_we), 32'd1);
        tick(); tick(); tick();
        check("pause_state", 32'(state), 32'd0);
        check("pause_mem_en", 32'(mem_bus.mem_en), 32'd0);
        check("pause_pc", 32'(pc), 32'h0001);
        run_en = 1;
        tick();
        check("resume_state", 32'(state), 32'd1);
        check("resume_mem_en", 32'(mem_bus.mem_en), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
